pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
Consumer end of the hazard path in the 5-stage ARM pipeline. Takes the Hazard flag from the hazard detection unit, Branch_taken from the EXE stage and Mem_busy from the SRAM controller. Drives per-stage freeze, flush and bubble controls for PC, IF/ID, ID/EX and the back-end registers. Adds a memory-wait watchdog FSM and optional stall/flush performance counters.

Parameters:
MAX_WAIT, 16, consecutive Mem_busy cycles tolerated before a timeout is declared; must be >= 2.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  pipeline clock.
rst  in  1  asynchronous, active-high reset.
Hazard  in  1  RAW hazard from the hazard detection unit; combinational, same cycle.
Branch_taken  in  1  taken branch resolved in EXE this cycle.
Mem_busy  in  1  SRAM controller not ready; MEM stage must hold.
Clr_cnt  in  1  synchronous clear of the performance counters.
Freeze_PC  out  1  hold the PC.
Freeze_IF_ID  out  1  hold the IF/ID register.
Flush_IF_ID  out  1  load NOP into IF/ID.
Flush_ID_EX  out  1  load bubble into ID/EX.
Freeze_Back  out  1  hold ID/EX, EXE/MEM and MEM/WB.
Timeout_err  out  1  sticky memory-timeout flag.
Stall_cnt  out  CNT_W  number of cycles with Freeze_PC=1.
Hazard_cnt  out  CNT_W  number of hazard bubbles inserted.
Flush_cnt  out  CNT_W  number of branch flushes.

Behaviour:
Control outputs:
- Freeze/flush outputs are combinational from the current state and inputs, with no added latency.
- Only the state, wait counter, error flag and performance counters are registered.

FSM states: RUN, MEM_WAIT, TIMEOUT. Reset puts the FSM in RUN, clears wait_cnt, Timeout_err and all counters.

Output priority in RUN and MEM_WAIT (highest first):
1. Mem_busy=1 -> Freeze_PC=Freeze_IF_ID=Freeze_Back=1, both flushes 0. Hazard and Branch_taken are ignored; the frozen pipeline re-presents them later.
2. Else Branch_taken=1 -> Flush_IF_ID=Flush_ID_EX=1, all freezes 0. Hazard is ignored because the instruction in ID is squashed.
3. Else Hazard=1 -> Freeze_PC=Freeze_IF_ID=1, Flush_ID_EX=1 (bubble), Freeze_Back=0, Flush_IF_ID=0.
4. Else all control outputs 0.

TIMEOUT: Freeze_PC=Freeze_IF_ID=Freeze_Back=1, flushes 0, Timeout_err=1. Only rst exits this state.

Transitions, evaluated at the clk edge:
- RUN, Mem_busy=1 -> MEM_WAIT, wait_cnt=1.
- MEM_WAIT, Mem_busy=1 -> wait_cnt increments. If the incremented value equals MAX_WAIT, go to TIMEOUT.
  - Timeout_err therefore rises in the cycle after the MAX_WAIT-th consecutive busy cycle.
- MEM_WAIT, Mem_busy=0 -> RUN, wait_cnt=0. That cycle follows the normal priority rules (branch or hazard may act).
- A busy burst of exactly MAX_WAIT-1 cycles never times out.

Reset mid-operation: asynchronous. All state and outputs return to reset values immediately. Control outputs then follow the RUN rules on the current inputs.

Counters:
- Each counter increments by 1 per qualifying cycle and saturates at all-ones.
- Clr_cnt has priority over increment.
- Qualifying cycles: Stall_cnt when Freeze_PC=1 (any state); Hazard_cnt when rule 3 fires; Flush_cnt when rule 2 fires.

Optional Feature:
Macro STALL_PERF_CNT_EN.
- Defined: the counters are implemented as described above.
- Undefined: no counter flops are built; Stall_cnt, Hazard_cnt and Flush_cnt are tied to 0 and Clr_cnt is ignored. The port list is unchanged.

Decomposition:
Shared package holds:
- the state encoding (RUN=2'd0, MEM_WAIT=2'd1, TIMEOUT=2'd2);
- the default MAX_WAIT and CNT_W constants.

One natural sub-module: sat_counter, a CNT_W-wide saturating counter with inc and clr inputs. It is instantiated three times under STALL_PERF_CNT_EN.

Test Plan:
- Hazard=1 for one cycle, other inputs 0 -> Freeze_PC=Freeze_IF_ID=Flush_ID_EX=1 in that same cycle, Freeze_Back=0; Hazard_cnt=1 and Stall_cnt=1 afterwards.
- Hazard=1 and Branch_taken=1 together -> only Flush_IF_ID=Flush_ID_EX=1; Flush_cnt=1, Hazard_cnt=0.
- Mem_busy=1 for 5 cycles with Hazard=1 throughout, MAX_WAIT=16 -> all freezes high for 5 cycles with no flushes. On release the FSM returns to RUN and the hazard bubble fires; Stall_cnt=6.
- Mem_busy held for 16 cycles with MAX_WAIT=16 -> Timeout_err=1 from cycle 17 and stays high after Mem_busy drops. A 15-cycle burst gives no error.
- Assert rst during MEM_WAIT and during TIMEOUT -> Timeout_err=0, counters=0, outputs follow RUN rules immediately.
- Drive 2^CNT_W+3 hazard cycles with CNT_W=4 -> Hazard_cnt saturates at 15. Clr_cnt coincident with a hazard -> Hazard_cnt=0 next cycle. With the macro undefined, all counters read 0.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller: watchdog FSM state
// encoding and default parameter values.
package pipeline_stall_controller_pkg;

    // Memory-wait watchdog states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    // Consecutive busy cycles tolerated before a timeout (must be >= 2)
    localparam int DEFAULT_MAX_WAIT = 16;
    // Width of each performance counter
    localparam int DEFAULT_CNT_W    = 16;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// sat_counter: CNT_W-wide up counter that sticks at all-ones. A synchronous
// clear takes priority over an increment in the same cycle.
module sat_counter
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count qualifying cycles, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: turns Hazard, Branch_taken and Mem_busy into
// per-stage freeze/flush controls, with a memory-wait watchdog FSM.
// Optional feature: define STALL_PERF_CNT_EN to build the stall/hazard/flush
// performance counters; otherwise they read 0 and Clr_cnt is ignored.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Hazard,
    input  logic             Branch_taken,
    input  logic             Mem_busy,
    input  logic             Clr_cnt,
    output logic             Freeze_PC,
    output logic             Freeze_IF_ID,
    output logic             Flush_IF_ID,
    output logic             Flush_ID_EX,
    output logic             Freeze_Back,
    output logic             Timeout_err,
    output logic [CNT_W-1:0] Stall_cnt,
    output logic [CNT_W-1:0] Hazard_cnt,
    output logic [CNT_W-1:0] Flush_cnt
);

    // Wide enough to hold MAX_WAIT itself
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    // Qualifying events for the performance counters
    logic hazard_bubble;
    logic branch_flush;

    // State, wait counter and sticky error flag
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and same-cycle freeze/flush controls
    // NOTE: every signal driven here gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        err_d         = err_q;
        Freeze_PC     = 1'b0;
        Freeze_IF_ID  = 1'b0;
        Flush_IF_ID   = 1'b0;
        Flush_ID_EX   = 1'b0;
        Freeze_Back   = 1'b0;
        hazard_bubble = 1'b0;
        branch_flush  = 1'b0;

        if (state_q == TIMEOUT) begin
            // Locked up until reset: hold the whole pipeline
            Freeze_PC    = 1'b1;
            Freeze_IF_ID = 1'b1;
            Freeze_Back  = 1'b1;
        end else if (Mem_busy) begin
            // Memory stall wins; hazard/branch are re-presented later
            Freeze_PC    = 1'b1;
            Freeze_IF_ID = 1'b1;
            Freeze_Back  = 1'b1;
        end else if (Branch_taken) begin
            // Squash the two younger instructions; hazard in ID is moot
            Flush_IF_ID  = 1'b1;
            Flush_ID_EX  = 1'b1;
            branch_flush = 1'b1;
        end else if (Hazard) begin
            // Hold front end and inject a bubble into EXE
            Freeze_PC     = 1'b1;
            Freeze_IF_ID  = 1'b1;
            Flush_ID_EX   = 1'b1;
            hazard_bubble = 1'b1;
        end

        unique case (state_q)
            RUN: begin
                if (Mem_busy) begin
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (Mem_busy) begin
                    wait_d = wait_q + WAIT_W'(1);
                    if ((wait_q + WAIT_W'(1)) == WAIT_W'(MAX_WAIT)) begin
                        state_d = TIMEOUT;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                    wait_d  = '0;
                end
            end
            TIMEOUT: begin
                state_d = TIMEOUT;
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    assign Timeout_err = err_q;

`ifdef STALL_PERF_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (Freeze_PC),
        .clr   (Clr_cnt),
        .count (Stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_hazard_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hazard_bubble),
        .clr   (Clr_cnt),
        .count (Hazard_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (branch_flush),
        .clr   (Clr_cnt),
        .count (Flush_cnt)
    );
`else
    // Counters not built: outputs read 0, counter inputs are left unused
    logic cnt_unused;
    assign cnt_unused = ^{Clr_cnt, hazard_bubble, branch_flush};
    assign Stall_cnt  = '0;
    assign Hazard_cnt = '0;
    assign Flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed scenarios plus
// randomized stimulus, compared against a behavioural model every cycle.
module tb_pipeline_stall_controller;

    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             hazard = 1'b0;
    logic             branch = 1'b0;
    logic             busy = 1'b0;
    logic             clr = 1'b0;
    logic             freeze_pc, freeze_if_id, flush_if_id, flush_id_ex;
    logic             freeze_back, timeout_err;
    logic [CNT_W-1:0] stall_cnt, hazard_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int busy_run;
    bit timed_out;
    int m_stall, m_haz, m_flush;

    pipeline_stall_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .Hazard       (hazard),
        .Branch_taken (branch),
        .Mem_busy     (busy),
        .Clr_cnt      (clr),
        .Freeze_PC    (freeze_pc),
        .Freeze_IF_ID (freeze_if_id),
        .Flush_IF_ID  (flush_if_id),
        .Flush_ID_EX  (flush_id_ex),
        .Freeze_Back  (freeze_back),
        .Timeout_err  (timeout_err),
        .Stall_cnt    (stall_cnt),
        .Hazard_cnt   (hazard_cnt),
        .Flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected controls: {fpc, fifid, flifid, flidex, fback, bubble, bflush}
    function automatic logic [6:0] model_ctrl();
        if (timed_out || busy) return 7'b11_00_1_00;
        if (branch)            return 7'b00_11_0_01;
        if (hazard)            return 7'b11_01_0_10;
        return 7'b0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        busy_run  = 0;
        timed_out = 0;
        m_stall   = 0;
        m_haz     = 0;
        m_flush   = 0;
    endtask

    // Advance the model by one clock using the inputs held across the edge
    task automatic model_clock();
        logic [6:0] c;
        c = model_ctrl();
        if (clr) begin
            m_stall = 0;
            m_haz   = 0;
            m_flush = 0;
        end else begin
            if (c[6]) m_stall = sat_inc(m_stall);
            if (c[1]) m_haz   = sat_inc(m_haz);
            if (c[0]) m_flush = sat_inc(m_flush);
        end
        if (!timed_out) begin
            if (busy) begin
                busy_run++;
                if (busy_run == MAX_WAIT) timed_out = 1;
            end else begin
                busy_run = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [6:0] c;
        c = model_ctrl();
        check("Freeze_PC",    32'(freeze_pc),    32'(c[6]));
        check("Freeze_IF_ID", 32'(freeze_if_id), 32'(c[5]));
        check("Flush_IF_ID",  32'(flush_if_id),  32'(c[4]));
        check("Flush_ID_EX",  32'(flush_id_ex),  32'(c[3]));
        check("Freeze_Back",  32'(freeze_back),  32'(c[2]));
        check("Timeout_err",  32'(timeout_err),  32'(timed_out));
`ifdef STALL_PERF_CNT_EN
        check("Stall_cnt",  32'(stall_cnt),  32'(m_stall));
        check("Hazard_cnt", 32'(hazard_cnt), 32'(m_haz));
        check("Flush_cnt",  32'(flush_cnt),  32'(m_flush));
`else
        check("Stall_cnt",  32'(stall_cnt),  32'd0);
        check("Hazard_cnt", 32'(hazard_cnt), 32'd0);
        check("Flush_cnt",  32'(flush_cnt),  32'd0);
`endif
    endtask

    // One clock: drive at posedge+1, check mid-cycle, advance model at edge
    task automatic step(input logic h, input logic b, input logic m, input logic c);
        hazard = h;
        branch = b;
        busy   = m;
        clr    = c;
        #2;
        check_all();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    // Asynchronous reset mid-cycle; outputs must follow RUN rules at once
    task automatic mid_reset(input logic h, input logic b, input logic m);
        hazard = h;
        branch = b;
        busy   = m;
        clr    = 1'b0;
        rst    = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2;
        check_all();
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single hazard cycle
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // Hazard and branch together: only the branch flush acts
        mid_reset(0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);

        // Five busy cycles with a hazard throughout, then release
        mid_reset(0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // 15-cycle burst never times out
        for (int i = 0; i < MAX_WAIT - 1; i++) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);

        // Reset during MEM_WAIT
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        mid_reset(1, 0, 1);
        step(0, 0, 0, 0);

        // 16-cycle burst times out; error is sticky after release
        for (int i = 0; i < MAX_WAIT; i++) step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Reset during TIMEOUT
        mid_reset(1, 0, 0);
        step(0, 1, 0, 0);

        // Saturation, then clear coincident with a hazard
        for (int i = 0; i < (1 << CNT_W) + 3; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
